// File: rtl/enc_pkg.sv
// Shared definitions for the registered priority / round-robin encoder.
package enc_pkg;

  // Search-mode encoding as seen on the mode input.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } enc_mode_e;

  // Index width for n request lines, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational search for the first set request at or after a start
// pointer, wrapping modulo N (N need not be a power of two).
module prio_find
  import enc_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = clog2_min1(N)
) (
  input  logic [N-1:0]    din,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] off;

  // (base + k) mod N, valid because base < N and k < N.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= N) s = s - N;
    return IDXW'(s);
  endfunction

  // Rotate din so that request ptr lands at bit 0.
  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rot[k] = din[wrap_add(ptr, k)];
    end
  end

  // Lowest set bit of the rotated vector; scanning downward leaves the lowest.
  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = IDXW'(k);
        found = 1'b1;
      end
    end
  end

  // Undo the rotation to get the absolute request index.
  assign idx = wrap_add(ptr, 32'(off));

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with fixed-priority and round-robin modes
// and a valid/ready output stage giving one result per cycle.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    din,
  input  logic            mode,
  output logic            in_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_valid,
  output logic            out_multi,
  input  logic            out_ready
);

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] search_ptr;
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic            capture;
  logic            multi;
  logic            rr_sel;

  assign rr_sel = (enc_mode_e'(mode) == MODE_RR);

  // Fixed priority is round-robin search anchored at index 0.
  assign search_ptr = rr_sel ? rr_ptr : '0;

  prio_find #(
    .N    (N),
    .IDXW (IDXW)
  ) u_find (
    .din   (din),
    .ptr   (search_ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  assign capture = en && win_found && in_ready;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = (din & (din - {{(N-1){1'b0}}, 1'b1})) != '0;

  // Result register, handshake state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_multi <= 1'b0;
      rr_ptr    <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_idx   <= win_idx;
      out_multi <= multi;
      if (rr_sel) begin
        rr_ptr <= (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench: table-driven vectors on an N=8 instance and a hand-written
// sequence on an N=5 instance.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // N=8 instance
  logic       rst8, en8, mode8, ordy8;
  logic [7:0] din8;
  logic       irdy8, ovld8, omulti8;
  logic [2:0] oidx8;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk       (clk),
    .rst       (rst8),
    .en        (en8),
    .din       (din8),
    .mode      (mode8),
    .in_ready  (irdy8),
    .out_idx   (oidx8),
    .out_valid (ovld8),
    .out_multi (omulti8),
    .out_ready (ordy8)
  );

  // N=5 instance
  logic       rst5, en5, mode5, ordy5;
  logic [4:0] din5;
  logic       irdy5, ovld5, omulti5;
  logic [2:0] oidx5;

  prio_encoder_rr #(.N(5)) dut5 (
    .clk       (clk),
    .rst       (rst5),
    .en        (en5),
    .din       (din5),
    .mode      (mode5),
    .in_ready  (irdy5),
    .out_idx   (oidx5),
    .out_valid (ovld5),
    .out_multi (omulti5),
    .out_ready (ordy5)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] din;
    logic       ordy;
    logic       ev;
    logic [2:0] ei;
    logic       em;
    logic       eir;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst8 = 1'b1; en8 = 1'b0; mode8 = 1'b0; ordy8 = 1'b0; din8 = '0;
    rst5 = 1'b1; en5 = 1'b0; mode5 = 1'b0; ordy5 = 1'b0; din5 = '0;

    //              rst en mode din    ordy  ev ei    em eir
    vecs.push_back('{1, 1, 0, 8'hFF, 1,    0, 3'd0, 0, 1});
    vecs.push_back('{1, 1, 0, 8'hFF, 1,    0, 3'd0, 0, 1});
    for (int i = 0; i < 8; i++) begin
      vecs.push_back('{0, 1, 0, 8'(1 << i), 1, 1, 3'(i), 0, 1});
    end
    vecs.push_back('{0, 1, 0, 8'hA4, 1,    1, 3'd2, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h85, 1,    1, 3'd0, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h85, 1,    1, 3'd2, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h85, 1,    1, 3'd7, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h85, 1,    1, 3'd0, 1, 1});
    vecs.push_back('{0, 1, 0, 8'h10, 1,    1, 3'd4, 0, 1});
    vecs.push_back('{0, 1, 1, 8'h02, 0,    1, 3'd4, 0, 0});
    vecs.push_back('{0, 1, 0, 8'h02, 0,    1, 3'd4, 0, 0});
    vecs.push_back('{0, 1, 1, 8'h02, 0,    1, 3'd4, 0, 0});
    vecs.push_back('{0, 1, 0, 8'h02, 1,    1, 3'd1, 0, 1});
    vecs.push_back('{0, 0, 0, 8'h00, 1,    0, 3'd1, 0, 1});
    vecs.push_back('{0, 0, 0, 8'h00, 1,    0, 3'd1, 0, 1});
    vecs.push_back('{0, 1, 0, 8'h00, 1,    0, 3'd1, 0, 1});
    vecs.push_back('{0, 1, 0, 8'hC0, 1,    1, 3'd6, 1, 1});
    vecs.push_back('{0, 0, 0, 8'h00, 0,    1, 3'd6, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 1,    0, 3'd6, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h81, 1,    1, 3'd7, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h81, 1,    1, 3'd0, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h81, 0,    1, 3'd0, 1, 0});
    vecs.push_back('{1, 1, 1, 8'hFF, 0,    0, 3'd0, 0, 1});
    vecs.push_back('{0, 1, 1, 8'h81, 1,    1, 3'd0, 1, 1});
    vecs.push_back('{0, 1, 1, 8'h08, 1,    1, 3'd3, 0, 1});

    for (int v = 0; v < vecs.size(); v++) begin
      rst8  = vecs[v].rst;
      en8   = vecs[v].en;
      mode8 = vecs[v].mode;
      din8  = vecs[v].din;
      ordy8 = vecs[v].ordy;
      tick();
      chk($sformatf("v%0d out_valid", v), 32'(ovld8),   32'(vecs[v].ev));
      chk($sformatf("v%0d out_idx", v),   32'(oidx8),   32'(vecs[v].ei));
      chk($sformatf("v%0d out_multi", v), 32'(omulti8), 32'(vecs[v].em));
      chk($sformatf("v%0d in_ready", v),  32'(irdy8),   32'(vecs[v].eir));
    end

    // N=5 round-robin: wrap at index 4, then reset while a result is held.
    rst5 = 1'b1; en5 = 1'b1; din5 = 5'b11111; mode5 = 1'b1; ordy5 = 1'b1;
    tick();
    chk("n5 reset out_valid", 32'(ovld5), 32'd0);
    rst5 = 1'b0; din5 = 5'b10000;
    tick();
    chk("n5 idx4", 32'(oidx5), 32'd4);
    chk("n5 idx4 valid", 32'(ovld5), 32'd1);
    chk("n5 idx4 multi", 32'(omulti5), 32'd0);
    din5 = 5'b10001;
    tick();
    chk("n5 wrap idx0", 32'(oidx5), 32'd0);
    chk("n5 wrap multi", 32'(omulti5), 32'd1);
    en5 = 1'b0; ordy5 = 1'b0;
    tick();
    chk("n5 held valid", 32'(ovld5), 32'd1);
    chk("n5 held in_ready", 32'(irdy5), 32'd0);
    rst5 = 1'b1;
    tick();
    chk("n5 rst held valid", 32'(ovld5), 32'd0);
    chk("n5 rst held in_ready", 32'(irdy5), 32'd1);
    // Pointer back at 0 picks index 0; a stale pointer of 1 would pick 4.
    rst5 = 1'b0; en5 = 1'b1; ordy5 = 1'b1; din5 = 5'b10001;
    tick();
    chk("n5 post-rst idx", 32'(oidx5), 32'd0);
    chk("n5 post-rst valid", 32'(ovld5), 32'd1);
    // Pointer now 1: next search finds 4.
    tick();
    chk("n5 rr next idx", 32'(oidx5), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
